// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the host and the CoreUART transmitter, with registered read data.
// Define UART_TX_FIFO_OVF_EN to add the sticky overflow flag (ovf) and its clear (ovf_clr).
module uart_tx_fifo #(
   parameter int DEPTH_LOG2 = 4,
   parameter int WIDTH      = 8
) (
   input  logic                  clk,
   input  logic                  aresetn,
   input  logic                  flush,
   input  logic                  wr_en,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic                  rd_n,
   output logic [WIDTH-1:0]      rd_data,
   output logic                  empty,
   output logic                  full,
   output logic [DEPTH_LOG2:0]   level
`ifdef UART_TX_FIFO_OVF_EN
   ,
   output logic                  ovf,
   input  logic                  ovf_clr
`endif
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] PTR_INC = {{DEPTH_LOG2{1'b0}}, 1'b1};

   logic [WIDTH-1:0]    mem [DEPTH];
   logic [DEPTH_LOG2:0] wr_ptr;
   logic [DEPTH_LOG2:0] rd_ptr;
   logic                rd_acc;
   logic                wr_acc;

   // Status comes only from the registered pointers; the extra wrap bit separates full from empty.
   assign empty  = (wr_ptr == rd_ptr);
   assign full   = (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]) &&
                   (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]);
   assign level  = wr_ptr - rd_ptr;

   assign rd_acc = !rd_n && !empty;
   assign wr_acc = wr_en && (!full || rd_acc);

   always_ff @(posedge clk) begin
      if (wr_acc && !flush) begin
         mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         rd_data <= '0;
      end else if (flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         rd_data <= '0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + PTR_INC;
         end
         if (rd_acc) begin
            rd_data <= mem[rd_ptr[DEPTH_LOG2-1:0]];
            rd_ptr  <= rd_ptr + PTR_INC;
         end
      end
   end

`ifdef UART_TX_FIFO_OVF_EN
   // A dropped write sets the flag even when a clear arrives in the same cycle; flush leaves it alone.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         ovf <= 1'b0;
      end else if (wr_en && full && !rd_acc) begin
         ovf <= 1'b1;
      end else if (ovf_clr) begin
         ovf <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed testbench for uart_tx_fifo: a vector table for single-cycle behaviour plus
// hand-written fill/drain, wrap, flush and asynchronous reset sequences.
module tb_uart_tx_fifo;

   logic       clk = 1'b0;
   logic       aresetn = 1'b0;
   logic       flush = 1'b0;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       rd_n = 1'b1;
   logic [7:0] rd_data;
   logic       empty;
   logic       full;
   logic [4:0] level;
`ifdef UART_TX_FIFO_OVF_EN
   logic       ovf;
   logic       ovf_clr = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      name;
      logic       wr_en;
      logic [7:0] wr_data;
      logic       rd_n;
      logic       flush;
      logic [7:0] exp_rd_data;
      logic       exp_empty;
      logic       exp_full;
      logic [4:0] exp_level;
   } vec_t;

   vec_t vecs[10];

   uart_tx_fifo #(.DEPTH_LOG2(4), .WIDTH(8)) dut (
      .clk     (clk),
      .aresetn (aresetn),
      .flush   (flush),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .rd_n    (rd_n),
      .rd_data (rd_data),
      .empty   (empty),
      .full    (full),
      .level   (level)
`ifdef UART_TX_FIFO_OVF_EN
      ,
      .ovf     (ovf),
      .ovf_clr (ovf_clr)
`endif
   );

   always #5 clk = ~clk;

   // Drive one cycle of inputs, let one rising edge pass, then sample 1 time unit later.
   task automatic applyStimulus(input logic w, input logic [7:0] d, input logic r, input logic f);
      wr_en   = w;
      wr_data = d;
      rd_n    = r;
      flush   = f;
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      rd_n  = 1'b1;
      flush = 1'b0;
   endtask

   task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic checkOutput(input string name, input logic [7:0] exp_rd, input logic exp_empty,
                              input logic exp_full, input logic [4:0] exp_level);
      checkValue({name, " rd_data"}, {24'd0, rd_data}, {24'd0, exp_rd});
      checkValue({name, " empty"}, {31'd0, empty}, {31'd0, exp_empty});
      checkValue({name, " full"}, {31'd0, full}, {31'd0, exp_full});
      checkValue({name, " level"}, {27'd0, level}, {27'd0, exp_level});
   endtask

   initial begin
      logic [7:0] q[$];
      logic [7:0] exp_rd;
      logic       w;
      logic       r;
      logic       racc;
      logic       wacc;
      logic [7:0] d;

      vecs[0] = '{"wr A5",          1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 5'd1};
      vecs[1] = '{"rd A5",          1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 5'd0};
      vecs[2] = '{"rd on empty",    1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 5'd0};
      vecs[3] = '{"wr+rd on empty", 1'b1, 8'h3C, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 5'd1};
      vecs[4] = '{"rd 3C",          1'b0, 8'h00, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 5'd0};
      vecs[5] = '{"wr 11",          1'b1, 8'h11, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 5'd1};
      vecs[6] = '{"wr 22",          1'b1, 8'h22, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 5'd2};
      vecs[7] = '{"wr+rd mid",      1'b1, 8'h33, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0, 5'd2};
      vecs[8] = '{"rd 22",          1'b0, 8'h00, 1'b0, 1'b0, 8'h22, 1'b0, 1'b0, 5'd1};
      vecs[9] = '{"flush+wr+rd",    1'b1, 8'h44, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 5'd0};

      @(posedge clk);
      #1;
      checkOutput("in reset", 8'h00, 1'b1, 1'b0, 5'd0);
      @(posedge clk);
      #1;
      aresetn = 1'b1;
      checkOutput("after reset", 8'h00, 1'b1, 1'b0, 5'd0);
`ifdef UART_TX_FIFO_OVF_EN
      checkValue("reset ovf", {31'd0, ovf}, 32'd0);
`endif

      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i].wr_en, vecs[i].wr_data, vecs[i].rd_n, vecs[i].flush);
         checkOutput(vecs[i].name, vecs[i].exp_rd_data, vecs[i].exp_empty, vecs[i].exp_full,
                     vecs[i].exp_level);
      end

      // Fill to the top, then push one more that must be dropped.
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, 8'(i), 1'b1, 1'b0);
         checkValue("fill level", {27'd0, level}, 32'(i + 1));
      end
      checkOutput("full after 16", 8'h00, 1'b0, 1'b1, 5'd16);
      applyStimulus(1'b1, 8'hFF, 1'b1, 1'b0);
      checkOutput("17th dropped", 8'h00, 1'b0, 1'b1, 5'd16);
`ifdef UART_TX_FIFO_OVF_EN
      checkValue("ovf set", {31'd0, ovf}, 32'd1);
`endif

      applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
      checkOutput("wr+rd on full", 8'h00, 1'b0, 1'b1, 5'd16);
`ifdef UART_TX_FIFO_OVF_EN
      checkValue("ovf held", {31'd0, ovf}, 32'd1);
      ovf_clr = 1'b1;
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      ovf_clr = 1'b0;
      checkValue("ovf cleared", {31'd0, ovf}, 32'd0);
`endif

      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
         checkValue("drain data", {24'd0, rd_data}, (i < 15) ? 32'(i + 1) : 32'h55);
         checkValue("drain level", {27'd0, level}, 32'(15 - i));
      end
      checkOutput("drained", 8'h55, 1'b1, 1'b0, 5'd0);

      // Overlapping write and read streams, offset by 3 cycles, push the pointers across the wrap.
      exp_rd = 8'h55;
      for (int c = 0; c < 43; c++) begin
         w    = (c < 40);
         r    = (c >= 3);
         d    = 8'((c * 37 + 5) & 8'hFF);
         racc = r && (q.size() > 0);
         wacc = w && ((q.size() < 16) || racc);
         if (racc) exp_rd = q.pop_front();
         if (wacc) q.push_back(d);
         applyStimulus(w, d, !r, 1'b0);
         checkValue("stream data", {24'd0, rd_data}, {24'd0, exp_rd});
         checkValue("stream level", {27'd0, level}, 32'(q.size()));
      end
      checkOutput("stream end", exp_rd, 1'b1, 1'b0, 5'd0);

      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 8'(8'h61 + i), 1'b1, 1'b0);
      end
      checkValue("pre-flush level", {27'd0, level}, 32'd5);
      applyStimulus(1'b1, 8'h77, 1'b1, 1'b1);
      checkOutput("flush with write", 8'h00, 1'b1, 1'b0, 5'd0);

      applyStimulus(1'b1, 8'h81, 1'b1, 1'b0);
      applyStimulus(1'b1, 8'h82, 1'b1, 1'b0);
      applyStimulus(1'b1, 8'h83, 1'b0, 1'b0);
      checkOutput("before async reset", 8'h81, 1'b0, 1'b0, 5'd2);
      wr_en   = 1'b1;
      wr_data = 8'h84;
      #2;
      aresetn = 1'b0;
      #1;
      checkOutput("async reset", 8'h00, 1'b1, 1'b0, 5'd0);
      wr_en = 1'b0;
      @(posedge clk);
      #1;
      aresetn = 1'b1;
      applyStimulus(1'b1, 8'h99, 1'b1, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("after async reset", 8'h99, 1'b1, 1'b0, 5'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
